// File: rtl/e203_clkgate_ctrl.sv
// Per-unit clock-gating controller: idle-timeout gate-off, request-driven wake with settle delay.
// Optional all-off cycle statistics counter enabled by E203_CLKGATE_CTRL_STAT_EN.
module e203_clkgate_ctrl #(
  parameter int unsigned N_UNIT   = 4,
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_mode,
  input  logic [N_UNIT-1:0] force_on,
  input  logic [N_UNIT-1:0] unit_busy,
  input  logic [N_UNIT-1:0] wake_req,
  output logic [N_UNIT-1:0] wake_rdy,
  output logic [N_UNIT-1:0] clock_en,
  output logic              all_off,
  input  logic              stat_clr,
  output logic [31:0]       gated_cnt
);

  localparam int unsigned MAX_CYC = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_e;

  logic [N_UNIT-1:0] w_off;

  for (genvar gi = 0; gi < N_UNIT; gi++) begin : g_unit
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_idle;

    assign w_idle = ~(unit_busy[gi] | wake_req[gi] | force_on[gi] | test_mode);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= ST_ON;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Shared counter: idle run length in ON, settle time in WAKE.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_ON: begin
          if (!w_idle) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_W'(IDLE_CYC - 1)) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (!w_idle) begin
            w_state_nxt = ST_WAKE;
            w_cnt_nxt   = '0;
          end
        end
        ST_WAKE: begin
          if (r_cnt == CNT_W'(WAKE_CYC - 1)) begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Decoded straight from state flops so the gating enable cannot glitch.
    assign w_off[gi]    = (r_state == ST_OFF);
    assign clock_en[gi] = ~w_off[gi] | test_mode;
    assign wake_rdy[gi] = (r_state == ST_ON);
  end

  assign all_off = (&w_off) & ~test_mode;

`ifdef E203_CLKGATE_CTRL_STAT_EN
  logic [31:0] r_gated_cnt;

  // Clear wins over increment; count saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gated_cnt <= '0;
    end else if (stat_clr) begin
      r_gated_cnt <= '0;
    end else if (all_off && (r_gated_cnt != 32'hFFFF_FFFF)) begin
      r_gated_cnt <= r_gated_cnt + 32'd1;
    end
  end

  assign gated_cnt = r_gated_cnt;
`else
  logic w_unused_stat_clr;

  assign w_unused_stat_clr = stat_clr;
  assign gated_cnt         = '0;
`endif

endmodule

// File: tb/tb_e203_clkgate_ctrl.sv
// Self-checking bench for e203_clkgate_ctrl: cycle model feeds a scoreboard queue, plus directed checks.
// Honors E203_CLKGATE_CTRL_STAT_EN the same way as the design.
module tb_e203_clkgate_ctrl;

  localparam int N  = 4;
  localparam int IC = 16;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          test_mode = 1'b0;
  logic [N-1:0]  force_on = '0;
  logic [N-1:0]  unit_busy = '0;
  logic [N-1:0]  wake_req = '0;
  logic [N-1:0]  wake_rdy;
  logic [N-1:0]  clock_en;
  logic          all_off;
  logic          stat_clr = 1'b0;
  logic [31:0]   gated_cnt;

  e203_clkgate_ctrl #(.N_UNIT(N), .IDLE_CYC(IC), .WAKE_CYC(WC)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_mode (test_mode),
    .force_on  (force_on),
    .unit_busy (unit_busy),
    .wake_req  (wake_req),
    .wake_rdy  (wake_rdy),
    .clock_en  (clock_en),
    .all_off   (all_off),
    .stat_clr  (stat_clr),
    .gated_cnt (gated_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ce;
    logic [N-1:0] rdy;
    logic         aoff;
    logic [31:0]  gc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: off flag, remaining settle edges, idle run length.
  bit          m_off[N];
  int          m_wake_left[N];
  int          m_run[N];
  logic [31:0] m_gcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_all_off();
    logic a = ~test_mode;
    for (int i = 0; i < N; i++) a &= m_off[i];
    return a;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.ce[i]  = !m_off[i] || test_mode;
      e.rdy[i] = !m_off[i] && (m_wake_left[i] == 0);
    end
    e.aoff = model_all_off();
    e.gc   = m_gcnt;
    return e;
  endfunction

  task automatic model_edge();
    logic aoff_pre;
    logic idle;
    aoff_pre = model_all_off();
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_off[i] = 0; m_wake_left[i] = 0; m_run[i] = 0;
      end
      m_gcnt = '0;
    end else begin
`ifdef E203_CLKGATE_CTRL_STAT_EN
      if (stat_clr) m_gcnt = '0;
      else if (aoff_pre && m_gcnt != 32'hFFFF_FFFF) m_gcnt = m_gcnt + 32'd1;
`endif
      for (int i = 0; i < N; i++) begin
        idle = !(unit_busy[i] || wake_req[i] || force_on[i] || test_mode);
        if (m_off[i]) begin
          if (!idle) begin
            m_off[i] = 0;
            m_wake_left[i] = WC;
          end
        end else if (m_wake_left[i] > 0) begin
          m_wake_left[i]--;
        end else if (idle) begin
          m_run[i]++;
          if (m_run[i] == IC) begin
            m_off[i] = 1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  // One clock: model predicts at the edge, DUT outputs compared 1 time unit later.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_edge();
    sb.push_back(model_out());
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("clock_en", 32'(clock_en), 32'(e.ce));
      chk("wake_rdy", 32'(wake_rdy), 32'(e.rdy));
      chk("all_off", 32'(all_off), 32'(e.aoff));
      chk("gated_cnt", gated_cnt, e.gc);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  logic [31:0] stat5;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_off[i] = 0; m_wake_left[i] = 0; m_run[i] = 0;
    end
    m_gcnt = '0;
`ifdef E203_CLKGATE_CTRL_STAT_EN
    stat5 = 32'd5;
`else
    stat5 = 32'd0;
`endif

    // Reset, then all idle: gate-off after exactly IC idle edges.
    rst_n = 1'b0;
    cycle();
    chk("rst_ce", 32'(clock_en), 32'hF);
    chk("rst_rdy", 32'(wake_rdy), 32'hF);
    chk("rst_aoff", 32'(all_off), 32'd0);
    chk("rst_gcnt", gated_cnt, 32'd0);
    rst_n = 1'b1;
    cycles(IC - 1);
    chk("idle15_ce", 32'(clock_en), 32'hF);
    cycle();
    chk("idle16_ce", 32'(clock_en), 32'h0);
    chk("idle16_aoff", 32'(all_off), 32'd1);
    chk("idle16_gcnt", gated_cnt, 32'd0);

    // Statistics: five all-off cycles, then clear with all_off still high.
    cycles(5);
    chk("stat5", gated_cnt, stat5);
    stat_clr = 1'b1;
    cycle();
    chk("stat_clr", gated_cnt, 32'd0);
    stat_clr = 1'b0;

    // Unit 2 wake from OFF.
    wake_req[2] = 1'b1;
    cycle();
    chk("wake_k1_ce", 32'(clock_en), 32'h4);
    chk("wake_k1_rdy", 32'(wake_rdy), 32'h0);
    cycle();
    chk("wake_k2_rdy", 32'(wake_rdy), 32'h0);
    cycle();
    chk("wake_k3_rdy", 32'(wake_rdy), 32'h4);
    chk("wake_k3_aoff", 32'(all_off), 32'd0);
    wake_req[2] = 1'b0;
    cycles(20);

    // test_mode forces enables immediately; ready follows WAKE_CYC+1 edges later.
    test_mode = 1'b1;
    #1;
    chk("tm_ce_now", 32'(clock_en), 32'hF);
    chk("tm_aoff_now", 32'(all_off), 32'd0);
    cycles(WC);
    chk("tm_rdy_early", 32'(wake_rdy), 32'h0);
    cycle();
    chk("tm_rdy", 32'(wake_rdy), 32'hF);
    cycles(20);
    chk("tm_hold_rdy", 32'(wake_rdy), 32'hF);
    test_mode = 1'b0;
    cycles(IC + 1);

    // Reset during unit 1 WAKE with counter at 1.
    wake_req[1] = 1'b1;
    cycles(2);
    rst_n = 1'b0;
    cycle();
    chk("rstwake_ce1", 32'(clock_en[1]), 32'd1);
    chk("rstwake_rdy1", 32'(wake_rdy[1]), 32'd1);
    rst_n = 1'b1;
    wake_req[1] = 1'b0;
    cycles(IC - 1);
    chk("rstwake_cnt0_ce", 32'(clock_en), 32'hF);
    cycle();
    chk("rstwake_off_ce", 32'(clock_en), 32'h0);

    // Busy pulse on unit 0 restarts the full idle count.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycles(10);
    unit_busy[0] = 1'b1;
    cycle();
    unit_busy[0] = 1'b0;
    cycles(IC - 1);
    chk("pulse_ce0_on", 32'(clock_en), 32'h1);
    cycle();
    chk("pulse_ce0_off", 32'(clock_en), 32'h0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        unit_busy[i] = ($urandom_range(0, 39) == 0);
        wake_req[i]  = ($urandom_range(0, 59) == 0);
        force_on[i]  = ($urandom_range(0, 99) == 0);
      end
      if ($urandom_range(0, 299) == 0) test_mode = ~test_mode;
      stat_clr = ($urandom_range(0, 199) == 0);
      rst_n    = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
